// File: rtl/pow_n_pipe_hs_pkg.sv
// Shared defaults and helpers for the pipelined n^POW unit.
package pow_n_pipe_hs_pkg;

    localparam int unsigned DEF_W   = 8;
    localparam int unsigned DEF_POW = 5;
    localparam int unsigned DEF_RW  = 32;

    // One multiply stage per power beyond the first.
    function automatic int unsigned stages_of(input int unsigned pow);
        return pow - 1;
    endfunction

endpackage

// File: rtl/pow_n_pipe_hs_if.sv
// Operand/result handshake bundle for pow_n_pipe_hs; slave = the unit, master = its driver.
interface pow_n_pipe_hs_if
    import pow_n_pipe_hs_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned RW     = DEF_RW,
    parameter int unsigned STAGES = stages_of(DEF_POW)
) ();

    logic              n_vld;
    logic              n_rdy;
    logic [W-1:0]      n;
    logic              res_vld;
    logic              res_rdy;
    logic [RW-1:0]     res;
    logic              res_ovf;
    logic [STAGES-1:0] stage_vld;

    modport master (
        output n_vld, n, res_rdy,
        input  n_rdy, res_vld, res, res_ovf, stage_vld
    );

    modport slave (
        input  n_vld, n, res_rdy,
        output n_rdy, res_vld, res, res_ovf, stage_vld
    );

endinterface

// File: rtl/pow_n_pipe_hs_stage.sv
// One multiply stage: captures operand, running product and sticky overflow when loaded.
module pow_n_pipe_hs_stage
    import pow_n_pipe_hs_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned RW    = DEF_RW,
    parameter bit          FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_vld,
    input  logic [W-1:0]  i_op,
    input  logic [RW-1:0] i_p,
    input  logic          i_ovf,
    output logic          o_vld,
    output logic [W-1:0]  o_op,
    output logic [RW-1:0] o_p,
    output logic          o_ovf
);

    localparam int unsigned FW = RW + W;

    logic          r_vld;
    logic [W-1:0]  r_op;
    logic [RW-1:0] r_p;
    logic          r_ovf;

    logic [RW-1:0] w_a;
    logic [FW-1:0] w_full;
    logic          w_ovf_in;
    logic          w_ovf_hi;

    // First stage squares the operand; later stages extend the previous product.
    assign w_a      = FIRST ? RW'(i_op) : i_p;
    assign w_ovf_in = FIRST ? 1'b0 : i_ovf;
    assign w_full   = FW'(w_a) * FW'(i_op);
    assign w_ovf_hi = |w_full[FW-1:RW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_op  <= '0;
            r_p   <= '0;
            r_ovf <= 1'b0;
        end else if (i_load) begin
            r_vld <= i_vld;
            r_op  <= i_op;
            r_p   <= w_full[RW-1:0];
            r_ovf <= w_ovf_in | w_ovf_hi;
        end
    end

    assign o_vld = r_vld;
    assign o_op  = r_op;
    assign o_p   = r_p;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/pow_n_pipe_hs.sv
// Pipelined n^POW with valid/ready on both ends; bubbles collapse ahead of a stalled stage.
module pow_n_pipe_hs
    import pow_n_pipe_hs_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned POW = DEF_POW,
    parameter int unsigned RW  = DEF_RW
) (
    input  logic            clk,
    input  logic            rst,
    pow_n_pipe_hs_if.slave  bus
);

    localparam int unsigned STAGES = stages_of(POW);

    if (W < 1) begin : g_bad_w
        $error("pow_n_pipe_hs: W must be >= 1");
    end
    if (POW < 2 || POW > 8) begin : g_bad_pow
        $error("pow_n_pipe_hs: POW must be in 2..8");
    end
    if (RW < W) begin : g_bad_rw
        $error("pow_n_pipe_hs: RW must be >= W");
    end

    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_ovf;
    logic [STAGES-1:0] w_load;
    logic [W-1:0]      w_op [STAGES];
    logic [RW-1:0]     w_p  [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stage may load if downstream accepts or any stage from here to the output is empty.
        assign w_load[k] = bus.res_rdy | ~(&w_vld[STAGES-1:k]);

        if (k == 0) begin : g_first
            pow_n_pipe_hs_stage #(.W(W), .RW(RW), .FIRST(1'b1)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load[k]),
                .i_vld  (bus.n_vld),
                .i_op   (bus.n),
                .i_p    ('0),
                .i_ovf  (1'b0),
                .o_vld  (w_vld[k]),
                .o_op   (w_op[k]),
                .o_p    (w_p[k]),
                .o_ovf  (w_ovf[k])
            );
        end else begin : g_next
            pow_n_pipe_hs_stage #(.W(W), .RW(RW), .FIRST(1'b0)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load[k]),
                .i_vld  (w_vld[k-1]),
                .i_op   (w_op[k-1]),
                .i_p    (w_p[k-1]),
                .i_ovf  (w_ovf[k-1]),
                .o_vld  (w_vld[k]),
                .o_op   (w_op[k]),
                .o_p    (w_p[k]),
                .o_ovf  (w_ovf[k])
            );
        end
    end

    assign bus.n_rdy     = w_load[0] & ~rst;
    assign bus.res_vld   = w_vld[STAGES-1];
    assign bus.res       = w_p[STAGES-1];
    assign bus.res_ovf   = w_ovf[STAGES-1];
    assign bus.stage_vld = w_vld;

endmodule

// File: tb/tb_pow_n_pipe_hs.sv
// Directed and scoreboarded checks of pow_n_pipe_hs at W=8, POW=5, RW=32.
module tb_pow_n_pipe_hs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pow_n_pipe_hs_if #(.W(8), .RW(32), .STAGES(4)) bus ();

    pow_n_pipe_hs #(.W(8), .POW(5), .RW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {overflow, n^5 mod 2^32}; 255^5 fits easily in 64 bits.
    function automatic logic [32:0] model(input logic [7:0] x);
        logic [63:0] f;
        f = 64'd1;
        for (int i = 0; i < 5; i++) f = f * 64'(x);
        return {|f[63:32], f[31:0]};
    endfunction

    logic [7:0]  t_n   [7] = '{8'd0, 8'd1, 8'd2, 8'd17, 8'd16, 8'd255, 8'd85};
    logic [31:0] t_res [7] = '{32'd0, 32'd1, 32'd32, 32'd1419857, 32'd1048576,
                               32'h09F604FF, 32'd142085829};
    logic        t_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] s_res [6] = '{32'd1, 32'd32, 32'd243, 32'd1024, 32'd3125, 32'd7776};

    initial begin
        logic [32:0] q[$];
        logic [32:0] e;
        logic [31:0] held;
        logic        stalled;
        int          k, acc, got, sent;

        bus.n_vld   = 1'b0;
        bus.n       = '0;
        bus.res_rdy = 1'b1;

        // reset state
        step(); step();
        chk("rst_n_rdy", 64'(bus.n_rdy), 64'd0);
        chk("rst_res_vld", 64'(bus.res_vld), 64'd0);
        chk("rst_stage_vld", 64'(bus.stage_vld), 64'd0);
        chk("rst_res", 64'(bus.res), 64'd0);
        chk("rst_res_ovf", 64'(bus.res_ovf), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_n_rdy", 64'(bus.n_rdy), 64'd1);

        // single operand: latency and occupancy walk
        bus.n_vld = 1'b1;
        bus.n     = 8'd3;
        step();
        bus.n_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("walk_stage_vld", 64'(bus.stage_vld), 64'(4'b0001 << i));
            chk("walk_res_vld", 64'(bus.res_vld), (i == 3) ? 64'd1 : 64'd0);
            if (i < 3) step();
        end
        chk("single_res", 64'(bus.res), 64'd243);
        chk("single_ovf", 64'(bus.res_ovf), 64'd0);
        step();
        chk("single_drain", 64'(bus.res_vld), 64'd0);

        // back-to-back, including overflow cases
        for (int c = 0; c < 11; c++) begin
            if (c < 7) begin
                bus.n_vld = 1'b1;
                bus.n     = t_n[c];
            end else begin
                bus.n_vld = 1'b0;
            end
            step();
            if (c >= 3 && c - 3 < 7) begin
                chk("b2b_vld", 64'(bus.res_vld), 64'd1);
                chk("b2b_res", 64'(bus.res), 64'(t_res[c-3]));
                chk("b2b_ovf", 64'(bus.res_ovf), 64'(t_ovf[c-3]));
            end
        end
        chk("b2b_drain", 64'(bus.res_vld), 64'd0);

        // stall with full pipeline, then release
        bus.res_rdy = 1'b0;
        k   = 1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.n_vld = 1'b1;
            bus.n     = 8'(k);
            #1;
            if (bus.n_rdy) begin
                acc++;
                k++;
            end
            step();
        end
        bus.n = 8'(k);
        #1;
        chk("stall_accepted", 64'(acc), 64'd4);
        chk("stall_n_rdy", 64'(bus.n_rdy), 64'd0);
        chk("stall_stage_vld", 64'(bus.stage_vld), 64'hF);
        chk("stall_res_vld", 64'(bus.res_vld), 64'd1);
        chk("stall_res", 64'(bus.res), 64'd1);
        step();
        chk("stall_hold", 64'(bus.res), 64'd1);

        bus.res_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            bus.n_vld = (k <= 6);
            bus.n     = 8'(k);
            #1;
            if (bus.n_vld && bus.n_rdy) k++;
            if (bus.res_vld && bus.res_rdy) begin
                if (got < 6) chk("release_res", 64'(bus.res), 64'(s_res[got]));
                got++;
            end
            step();
        end
        bus.n_vld = 1'b0;
        chk("release_count", 64'(got), 64'd6);
        chk("release_accepted", 64'(k), 64'd7);

        // random handshake against scoreboard
        got     = 0;
        sent    = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            bus.n_vld   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.n       = 8'($urandom);
            bus.res_rdy = ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) chk("rand_hold", 64'(bus.res), 64'(held));
            if (bus.n_vld && bus.n_rdy) begin
                q.push_back(model(bus.n));
                sent++;
            end
            if (bus.res_vld && bus.res_rdy) begin
                if (q.size() == 0) begin
                    chk("rand_spurious", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rand_res", 64'({bus.res_ovf, bus.res}), 64'(e));
                end
                got++;
            end
            stalled = bus.res_vld && !bus.res_rdy;
            held    = bus.res;
            step();
        end
        chk("rand_count", 64'(got), 64'd1000);
        chk("rand_left", 64'(q.size()), 64'd0);

        // reset with items in flight
        bus.res_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.n_vld = 1'b1;
            bus.n     = 8'(c + 2);
            step();
        end
        bus.n_vld = 1'b0;
        #1;
        chk("flight_stage_vld", 64'(bus.stage_vld), 64'h7);
        rst = 1'b1;
        #1;
        chk("mid_rst_n_rdy", 64'(bus.n_rdy), 64'd0);
        step();
        chk("mid_rst_stage_vld", 64'(bus.stage_vld), 64'd0);
        chk("mid_rst_res_vld", 64'(bus.res_vld), 64'd0);
        rst = 1'b0;
        #1;
        chk("after_rst_n_rdy", 64'(bus.n_rdy), 64'd1);
        got = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.res_vld) got++;
            step();
        end
        chk("after_rst_emitted", 64'(got), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
